// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and limits for the UART transmit scheduler.
// States of the transfer FSM and the supported requester count.
package uart_tx_scheduler_pkg;

   localparam int SCHED_NUM_REQ_MAX = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_START,
      S_WAIT,
      S_DONE
   } type_sched_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Zero latency; no flow control, valid is low when req is all zero.
module rr_priority_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   int pos;

   // Scan offsets from the far end down so the smallest offset from ptr is the last write.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (req[pos]) begin
            valid = 1'b1;
            idx   = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin owner of the single UART transmitter: grant, load byte, start, wait, ack.
// req->gnt 1 cycle, gnt->tx_start 1 cycle, tx_complete->done 1 cycle; req held until gnt.
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = 8,
   parameter int TIMEOUT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          done,
   output logic                        uart_wr_data,
   output logic [DATA_W-1:0]           uart_wdata,
   output logic                        tx_start,
   input  logic                        tx_complete,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  owner,
   output logic                        timeout_err,
   input  logic                        err_clr
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

   type_sched_state_e   state, state_nxt;
   logic [IDX_W-1:0]    rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0]    owner_nxt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_vld;
   logic [TIMEOUT_W-1:0] wd, wd_nxt;
   logic [NUM_REQ-1:0]  gnt_nxt, done_nxt;
   logic                wr_nxt, start_nxt, busy_nxt, err_nxt;
   logic [DATA_W-1:0]   wdata_nxt;

   function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] cur);
      if (cur == IDX_W'(NUM_REQ - 1)) return '0;
      return cur + IDX_W'(1);
   endfunction

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         wd           <= '0;
         gnt          <= '0;
         done         <= '0;
         uart_wr_data <= 1'b0;
         uart_wdata   <= '0;
         tx_start     <= 1'b0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_nxt;
         rr_ptr       <= rr_ptr_nxt;
         owner        <= owner_nxt;
         wd           <= wd_nxt;
         gnt          <= gnt_nxt;
         done         <= done_nxt;
         uart_wr_data <= wr_nxt;
         uart_wdata   <= wdata_nxt;
         tx_start     <= start_nxt;
         busy         <= busy_nxt;
         timeout_err  <= err_nxt;
      end
   end

   // Outputs are decoded from the next state so each pulse lines up with its state.
   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      owner_nxt  = owner;
      wd_nxt     = wd;
      gnt_nxt    = '0;
      done_nxt   = '0;
      wr_nxt     = 1'b0;
      start_nxt  = 1'b0;
      wdata_nxt  = uart_wdata;
      err_nxt    = err_clr ? 1'b0 : timeout_err;

      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               state_nxt          = S_GRANT;
               owner_nxt          = pick_idx;
               gnt_nxt[pick_idx]  = 1'b1;
               wr_nxt             = 1'b1;
               wdata_nxt          = req_data[pick_idx*DATA_W +: DATA_W];
            end
         end
         S_GRANT: begin
            state_nxt = S_START;
            start_nxt = 1'b1;
         end
         S_START: begin
            state_nxt = S_WAIT;
            wd_nxt    = '0;
         end
         S_WAIT: begin
            if (wd != WD_MAX) wd_nxt = wd + TIMEOUT_W'(1);
            // A completion on the saturating cycle still counts as success.
            if (tx_complete) begin
               state_nxt       = S_DONE;
               done_nxt[owner] = 1'b1;
            end else if (wd_nxt == WD_MAX) begin
               state_nxt  = S_IDLE;
               err_nxt    = 1'b1;
               rr_ptr_nxt = ptr_after(owner);
            end
         end
         S_DONE: begin
            state_nxt  = S_IDLE;
            rr_ptr_nxt = ptr_after(owner);
         end
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed stimulus pushes expectations,
// a negedge monitor pops and compares gnt/done events, a responder plays the UART.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [15:0] req_data = 16'h0;
   logic [1:0]  gnt, done;
   logic        uart_wr_data, tx_start, busy, timeout_err;
   logic [7:0]  uart_wdata;
   logic [0:0]  owner;
   logic        err_clr = 1'b0;
   logic        resp_tc = 1'b0;
   logic        stim_tc = 1'b0;
   logic        tx_complete;

   assign tx_complete = resp_tc | stim_tc;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [1:0] g;
      logic [7:0] d;
      logic [0:0] own;
      int         at;
   } gnt_exp_t;

   typedef struct {
      logic [1:0] dn;
      int         at;
   } done_exp_t;

   gnt_exp_t  gq[$];
   done_exp_t dq[$];
   int        oq[$];

   int resp_delay = 0;
   bit resp_expect_done = 1'b0;
   int resp_cnt = 0;
   int resp_last_at = 0;

   // Watchdog narrowed to 4 bits: a transfer aborts after 15 cycles in S_WAIT.
   uart_tx_scheduler #(
      .NUM_REQ   (2),
      .DATA_W    (8),
      .TIMEOUT_W (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .done         (done),
      .uart_wr_data (uart_wr_data),
      .uart_wdata   (uart_wdata),
      .tx_start     (tx_start),
      .tx_complete  (tx_complete),
      .busy         (busy),
      .owner        (owner),
      .timeout_err  (timeout_err),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_start(output int a);
      a = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            a = cyc;
            break;
         end
      end
      if (a < 0) fail_now("wait_tx_start");
   endtask

   task automatic wait_gnt();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (gnt !== 2'b00 && gnt !== 2'bxx) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_now("wait_gnt");
   endtask

   task automatic wait_quiet();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (gq.size() == 0 && dq.size() == 0 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("wait_quiet");
      tick(1);
   endtask

   task automatic push_gnt(input logic [1:0] g, input logic [7:0] d, input int at);
      gnt_exp_t e;
      e.g   = g;
      e.d   = d;
      e.own = (g == 2'b10) ? 1'b1 : 1'b0;
      e.at  = at;
      gq.push_back(e);
      oq.push_back(int'(e.own));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},   32'(gnt), 32'h0);
      chk({tag, "_done"},  32'(done), 32'h0);
      chk({tag, "_wr"},    32'(uart_wr_data), 32'h0);
      chk({tag, "_wdata"}, 32'(uart_wdata), 32'h0);
      chk({tag, "_start"}, 32'(tx_start), 32'h0);
      chk({tag, "_busy"},  32'(busy), 32'h0);
      chk({tag, "_owner"}, 32'(owner), 32'h0);
      chk({tag, "_err"},   32'(timeout_err), 32'h0);
   endtask

   // Monitor: compare every gnt/done pulse against the head of its queue.
   logic prev_gnt = 1'b0;
   always @(negedge clk) begin
      gnt_exp_t  ge;
      done_exp_t de;
      if (gnt === 2'b01 || gnt === 2'b10 || gnt === 2'b11 || uart_wr_data === 1'b1) begin
         if (gq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_gnt actual=%b required=none (cycle %0d)", gnt, cyc);
         end else begin
            ge = gq.pop_front();
            chk("gnt", 32'(gnt), 32'(ge.g));
            chk("uart_wdata", 32'(uart_wdata), 32'(ge.d));
            chk("uart_wr_data", 32'(uart_wr_data), 32'h1);
            chk("owner", 32'(owner), 32'(ge.own));
            if (ge.at >= 0) chk("gnt_cycle", 32'(cyc), 32'(ge.at));
         end
      end
      if (prev_gnt || tx_start === 1'b1) chk("tx_start", 32'(tx_start), 32'(prev_gnt));
      prev_gnt = (gnt === 2'b01 || gnt === 2'b10);
      if (done === 2'b01 || done === 2'b10 || done === 2'b11) begin
         if (dq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%b required=none (cycle %0d)", done, cyc);
         end else begin
            de = dq.pop_front();
            chk("done", 32'(done), 32'(de.dn));
            chk("done_cycle", 32'(cyc), 32'(de.at));
         end
      end
   end

   // UART model: answers each tx_start with tx_complete after resp_delay cycles.
   initial begin
      int o;
      done_exp_t de;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            o = (oq.size() > 0) ? oq.pop_front() : 0;
            if (resp_delay > 0) begin
               repeat (resp_delay) @(negedge clk);
               resp_tc = 1'b1;
               if (resp_expect_done) begin
                  de.dn = (o == 1) ? 2'b10 : 2'b01;
                  de.at = cyc + 1;
                  dq.push_back(de);
               end
               resp_last_at = cyc + 1;
               resp_cnt++;
               @(negedge clk);
               resp_tc = 1'b0;
            end
         end
      end
   end

   initial begin
      int a;
      int cnt0;
      bit fired;

      // Reset state
      rst = 1'b1;
      tick(3);
      chk_all_zero("reset");
      rst = 1'b0;
      tick(2);

      // Single request, byte 0x55
      resp_delay = 8;
      resp_expect_done = 1'b1;
      req_data = {8'h00, 8'h55};
      req = 2'b01;
      push_gnt(2'b01, 8'h55, cyc + 1);
      wait_gnt();
      req = 2'b00;
      wait_quiet();
      chk("single_busy_after", 32'(busy), 32'h0);

      // Contention from a fresh pointer: 01,10,01,10
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      req_data = {8'hB1, 8'hA0};
      req = 2'b11;
      push_gnt(2'b01, 8'hA0, cyc + 1);
      push_gnt(2'b10, 8'hB1, -1);
      push_gnt(2'b01, 8'hA0, -1);
      push_gnt(2'b10, 8'hB1, -1);
      for (int t = 0; t < 4; t++) wait_gnt();
      req = 2'b00;
      wait_quiet();

      // Watchdog abort, no tx_complete
      resp_delay = 0;
      req_data = {8'hC3, 8'h3C};
      req = 2'b01;
      push_gnt(2'b01, 8'h3C, cyc + 1);
      wait_start(a);
      req = 2'b00;
      tick(15);
      chk("wd_err_before", 32'(timeout_err), 32'h0);
      chk("wd_busy_before", 32'(busy), 32'h1);
      tick(1);
      chk("wd_err_set", 32'(timeout_err), 32'h1);
      chk("wd_busy_after", 32'(busy), 32'h0);

      // Pointer advanced past the aborted owner
      resp_delay = 8;
      resp_expect_done = 1'b1;
      req = 2'b11;
      push_gnt(2'b10, 8'hC3, cyc + 1);
      wait_gnt();
      req = 2'b00;
      tick(4);
      chk("wd_err_sticky", 32'(timeout_err), 32'h1);
      wait_quiet();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("err_clr", 32'(timeout_err), 32'h0);

      // tx_complete on the saturation cycle wins
      resp_delay = 15;
      req_data = {8'h00, 8'h81};
      req = 2'b01;
      push_gnt(2'b01, 8'h81, cyc + 1);
      wait_gnt();
      req = 2'b00;
      wait_quiet();
      chk("race_complete_err", 32'(timeout_err), 32'h0);

      // err_clr coinciding with a timeout: set wins
      resp_delay = 0;
      req_data = {8'h7E, 8'h00};
      req = 2'b10;
      push_gnt(2'b10, 8'h7E, cyc + 1);
      wait_start(a);
      req = 2'b00;
      tick(15);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("race_clr_err", 32'(timeout_err), 32'h1);
      tick(1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("race_clr_after", 32'(timeout_err), 32'h0);

      // Spurious tx_complete while idle
      stim_tc = 1'b1;
      tick(1);
      stim_tc = 1'b0;
      tick(1);
      chk("spur_busy", 32'(busy), 32'h0);
      chk("spur_owner", 32'(owner), 32'h1);
      chk("spur_err", 32'(timeout_err), 32'h0);
      tick(2);

      // req[1] rising during S_WAIT waits for the current done
      resp_delay = 8;
      resp_expect_done = 1'b1;
      req_data = {8'hD2, 8'h5A};
      req = 2'b01;
      push_gnt(2'b01, 8'h5A, cyc + 1);
      cnt0 = resp_cnt;
      wait_start(a);
      tick(2);
      req = 2'b10;
      fired = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (resp_cnt != cnt0) begin
            fired = 1'b1;
            break;
         end
      end
      if (!fired) fail_now("wait_tx_complete");
      push_gnt(2'b10, 8'hD2, resp_last_at + 2);
      wait_gnt();
      req = 2'b00;
      wait_quiet();

      // Reset mid-transfer: pointer moved to 1 first, then reset in S_WAIT
      req_data = {8'hE4, 8'h4E};
      req = 2'b01;
      push_gnt(2'b01, 8'h4E, cyc + 1);
      wait_gnt();
      req = 2'b00;
      wait_quiet();
      resp_delay = 0;
      req = 2'b10;
      push_gnt(2'b10, 8'hE4, cyc + 1);
      wait_start(a);
      req = 2'b00;
      tick(3);
      rst = 1'b1;
      tick(1);
      chk_all_zero("midrst");
      rst = 1'b0;
      resp_delay = 8;
      req = 2'b11;
      push_gnt(2'b01, 8'h4E, cyc + 1);
      wait_gnt();
      req = 2'b00;
      wait_quiet();

      chk("gq_empty", 32'(gq.size()), 32'h0);
      chk("dq_empty", 32'(dq.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
